// File: rtl/pcs_am_pkg.sv
// Shared definitions for the 40G PCS TX alignment-marker path.
//   BLOCK_W / LANES    : 66-bit blocks on four PCS lanes
//   SH_CTRL / SH_DATA  : sync-header values as seen in bits [1:0]
//   AM_M               : per-lane M0/M1/M2 marker bytes
//   bip3_of()          : BIP3 contribution of one 66-bit block
//   am_block_of()      : assembles a marker block from M bytes and a BIP3
package pcs_am_pkg;

  localparam int unsigned BLOCK_W = 66;
  localparam int unsigned LANES   = 4;

  localparam logic [1:0] SH_CTRL = 2'b01;
  localparam logic [1:0] SH_DATA = 2'b10;

  // AM_M[lane][k] = Mk for that lane
  localparam logic [7:0] AM_M [LANES][3] = '{
    '{8'h90, 8'h76, 8'h47},
    '{8'hF0, 8'hC4, 8'hE6},
    '{8'hC5, 8'h65, 8'h9B},
    '{8'hA2, 8'h79, 8'h3D}
  };

  // Bits 2..65 fold into BIP bit (i-2) mod 8; the two sync-header bits
  // additionally land on BIP bits 3 and 4.
  function automatic logic [7:0] bip3_of(input logic [BLOCK_W-1:0] b);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 2; i < BLOCK_W; i++) begin
      r[3'((i - 2) % 8)] ^= b[i];
    end
    r[3] ^= b[0];
    r[4] ^= b[1];
    return r;
  endfunction

  function automatic logic [BLOCK_W-1:0] am_block_of(input logic [7:0] m0,
                                                     input logic [7:0] m1,
                                                     input logic [7:0] m2,
                                                     input logic [7:0] bip3);
    return {~bip3, ~m2, ~m1, ~m0, bip3, m2, m1, m0, SH_CTRL};
  endfunction

endpackage

// File: rtl/am_bip_acc.sv
// Per-lane running BIP accumulator.
//   clk, reset  : clock, asynchronous active-low reset
//   clear       : synchronous clear (insertion disabled)
//   emit        : a block is being emitted on this lane this cycle
//   is_am       : the emitted block is an alignment marker
//   block       : the emitted 66-bit block
//   bip         : current accumulated BIP3 (value the next AM carries)
module am_bip_acc
  import pcs_am_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               emit,
  input  logic               is_am,
  input  logic [BLOCK_W-1:0] block,
  output logic [7:0]         bip
);

  // An emitted AM restarts the window with its own parity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bip <= '0;
    end else if (clear) begin
      bip <= '0;
    end else if (emit) begin
      bip <= is_am ? bip3_of(block) : (bip ^ bip3_of(block));
    end
  end

endmodule

// File: rtl/am_inserter.sv
// TX alignment-marker inserter for the 4-lane 40G PCS.
// Every AM_PERIOD output blocks one cycle is spent emitting per-lane
// alignment markers (upstream sees in_ready low for that cycle).
//   clk, reset        : clock, asynchronous active-low reset
//   am_en             : 1 = insert markers, 0 = registered bypass
//   in_valid/in_ready : input beat handshake
//   laneN_data_in     : per-lane 66-bit blocks, bits [1:0] sync header
//   laneN_data_out    : registered per-lane blocks
//   out_valid, is_am  : output block present / output is a marker
//   block_count       : output position in period (AM_PERIOD-1 on AM)
//   bip_err_inject    : only with AM_BIP_INJECT_EN; corrupts BIP3 bit0
//                       of the next AM on the flagged lanes
module am_inserter
  import pcs_am_pkg::*;
#(
  parameter int unsigned AM_PERIOD = 16384
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               am_en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] lane0_data_in,
  input  logic [BLOCK_W-1:0] lane1_data_in,
  input  logic [BLOCK_W-1:0] lane2_data_in,
  input  logic [BLOCK_W-1:0] lane3_data_in,
`ifdef AM_BIP_INJECT_EN
  input  logic [LANES-1:0]   bip_err_inject,
`endif
  output logic [BLOCK_W-1:0] lane0_data_out,
  output logic [BLOCK_W-1:0] lane1_data_out,
  output logic [BLOCK_W-1:0] lane2_data_out,
  output logic [BLOCK_W-1:0] lane3_data_out,
  output logic               out_valid,
  output logic               is_am,
  output logic [13:0]        block_count
);

  localparam logic [13:0] LAST = 14'(AM_PERIOD - 1);

  logic [13:0]        pos;
  logic               am_cycle;
  logic               accept;
  logic [BLOCK_W-1:0] din      [LANES];
  logic [BLOCK_W-1:0] dout     [LANES];
  logic [BLOCK_W-1:0] am_blk   [LANES];
  logic [BLOCK_W-1:0] emit_blk [LANES];
  logic [7:0]         acc      [LANES];
  logic [LANES-1:0]   inj_flag;

  assign din[0] = lane0_data_in;
  assign din[1] = lane1_data_in;
  assign din[2] = lane2_data_in;
  assign din[3] = lane3_data_in;

  assign lane0_data_out = dout[0];
  assign lane1_data_out = dout[1];
  assign lane2_data_out = dout[2];
  assign lane3_data_out = dout[3];

  assign am_cycle = am_en && (pos == LAST);
  assign accept   = am_en && !am_cycle && in_valid;
  assign in_ready = !am_en || (pos != LAST);

`ifdef AM_BIP_INJECT_EN
  // Sticky per-lane request; consumed by the AM emitted this cycle, while
  // a request arriving in that same cycle is kept for the following AM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inj_flag <= '0;
    end else if (am_cycle) begin
      inj_flag <= bip_err_inject;
    end else begin
      inj_flag <= inj_flag | bip_err_inject;
    end
  end
`else
  assign inj_flag = '0;
`endif

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    assign am_blk[n]   = am_block_of(AM_M[n][0], AM_M[n][1], AM_M[n][2],
                                     acc[n] ^ {7'd0, inj_flag[n]});
    assign emit_blk[n] = am_cycle ? am_blk[n] : din[n];

    am_bip_acc u_acc (
      .clk   (clk),
      .reset (reset),
      .clear (!am_en),
      .emit  (am_cycle || accept),
      .is_am (am_cycle),
      .block (emit_blk[n]),
      .bip   (acc[n])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos         <= LAST;
      out_valid   <= 1'b0;
      is_am       <= 1'b0;
      block_count <= '0;
      for (int unsigned n = 0; n < LANES; n++) dout[n] <= '0;
    end else if (!am_en) begin
      pos         <= LAST;
      out_valid   <= in_valid;
      is_am       <= 1'b0;
      block_count <= '0;
      for (int unsigned n = 0; n < LANES; n++) dout[n] <= din[n];
    end else if (am_cycle) begin
      pos         <= '0;
      out_valid   <= 1'b1;
      is_am       <= 1'b1;
      block_count <= LAST;
      for (int unsigned n = 0; n < LANES; n++) dout[n] <= am_blk[n];
    end else if (in_valid) begin
      pos         <= pos + 14'd1;
      out_valid   <= 1'b1;
      is_am       <= 1'b0;
      block_count <= pos;
      for (int unsigned n = 0; n < LANES; n++) dout[n] <= din[n];
    end else begin
      // no beat: data and count hold, nothing is emitted
      out_valid   <= 1'b0;
      is_am       <= 1'b0;
    end
  end

endmodule
